// File: rtl/dpram_port_arbiter.sv
// rtl/dpram_port_arbiter.sv - round-robin two-port grant arbiter for a shared dual-port RAM
module dpram_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 10
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         resp_valid,
  output logic [DATA_W-1:0]          resp_rdata,
  output logic                       ram_we_0,
  output logic [ADDR_W-1:0]          ram_addr_0,
  output logic [DATA_W-1:0]          ram_wdata_0,
  input  logic [DATA_W-1:0]          ram_rdata_0,
  output logic                       ram_we_1,
  output logic [ADDR_W-1:0]          ram_addr_1,
  output logic [DATA_W-1:0]          ram_wdata_1,
  input  logic [DATA_W-1:0]          ram_rdata_1
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              tag0_vld_q, tag0_vld_d;
  logic [IDX_W-1:0]  tag0_idx_q, tag0_idx_d;
  logic              tag1_vld_q, tag1_vld_d;
  logic [IDX_W-1:0]  tag1_idx_q, tag1_idx_d;
  logic              hold_vld_q, hold_vld_d;
  logic [IDX_W-1:0]  hold_idx_q, hold_idx_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;

  logic              gnt_a, gnt_b;
  logic [IDX_W-1:0]  idx_a, idx_b;
  logic [ADDR_W-1:0] addr_a;
  logic              write_a;
  logic              rd_block;

  logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
  logic [DATA_W-1:0] wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
  end

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == LAST_IDX) ? '0 : i + IDX_W'(1);
  endfunction

  // Both read tags live means the response slot after next belongs to the
  // holding register, so no read may be granted on either port this cycle.
  always_comb begin
    logic [IDX_W-1:0] idx;
    logic             cand;
    gnt_a    = 1'b0;
    gnt_b    = 1'b0;
    idx_a    = '0;
    idx_b    = '0;
    addr_a   = '0;
    write_a  = 1'b0;
    cand     = 1'b0;
    rd_block = tag0_vld_q & tag1_vld_q;
    idx      = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = reset_n & req_valid[idx] & (req_write[idx] | ~rd_block);
      if (cand && !gnt_a) begin
        gnt_a   = 1'b1;
        idx_a   = idx;
        addr_a  = addr_arr[idx];
        write_a = req_write[idx];
      end else if (cand && !gnt_b &&
                   !((addr_arr[idx] == addr_a) && (write_a || req_write[idx]))) begin
        gnt_b = 1'b1;
        idx_b = idx;
      end
      idx = next_idx(idx);
    end
  end

  always_comb begin
    req_ready   = '0;
    ram_we_0    = 1'b0;
    ram_addr_0  = '0;
    ram_wdata_0 = '0;
    ram_we_1    = 1'b0;
    ram_addr_1  = '0;
    ram_wdata_1 = '0;
    tag0_vld_d  = 1'b0;
    tag0_idx_d  = idx_a;
    tag1_vld_d  = 1'b0;
    tag1_idx_d  = idx_b;
    rr_ptr_d    = rr_ptr_q;
    if (gnt_a) begin
      req_ready[idx_a] = 1'b1;
      ram_we_0         = req_write[idx_a];
      ram_addr_0       = addr_arr[idx_a];
      ram_wdata_0      = wdata_arr[idx_a];
      tag0_vld_d       = ~req_write[idx_a];
      rr_ptr_d         = next_idx(idx_a);
    end
    if (gnt_b) begin
      req_ready[idx_b] = 1'b1;
      ram_we_1         = req_write[idx_b];
      ram_addr_1       = addr_arr[idx_b];
      ram_wdata_1      = wdata_arr[idx_b];
      tag1_vld_d       = ~req_write[idx_b];
      rr_ptr_d         = next_idx(idx_b);
    end
    hold_vld_d  = tag0_vld_q & tag1_vld_q;
    hold_idx_d  = tag1_idx_q;
    hold_data_d = hold_vld_d ? ram_rdata_1 : hold_data_q;
  end

  // tag1 and hold are never live together, nor are hold and tag0,
  // so the priority order here never drops a completion.
  always_comb begin
    resp_valid = '0;
    resp_rdata = '0;
    if (tag0_vld_q) begin
      resp_valid[tag0_idx_q] = 1'b1;
      resp_rdata             = ram_rdata_0;
    end else if (tag1_vld_q) begin
      resp_valid[tag1_idx_q] = 1'b1;
      resp_rdata             = ram_rdata_1;
    end else if (hold_vld_q) begin
      resp_valid[hold_idx_q] = 1'b1;
      resp_rdata             = hold_data_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q    <= '0;
      tag0_vld_q  <= 1'b0;
      tag0_idx_q  <= '0;
      tag1_vld_q  <= 1'b0;
      tag1_idx_q  <= '0;
      hold_vld_q  <= 1'b0;
      hold_idx_q  <= '0;
      hold_data_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      tag0_vld_q  <= tag0_vld_d;
      tag0_idx_q  <= tag0_idx_d;
      tag1_vld_q  <= tag1_vld_d;
      tag1_idx_q  <= tag1_idx_d;
      hold_vld_q  <= hold_vld_d;
      hold_idx_q  <= hold_idx_d;
      hold_data_q <= hold_data_d;
    end
  end

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// tb/tb_dpram_port_arbiter.sv - scoreboard bench for dpram_port_arbiter with a behavioural RAM
module tb_dpram_port_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_write, req_ready, resp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   resp_rdata;
  logic            ram_we_0, ram_we_1;
  logic [AW-1:0]   ram_addr_0, ram_addr_1;
  logic [DW-1:0]   ram_wdata_0, ram_wdata_1, ram_rdata_0, ram_rdata_1;

  dpram_port_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .ram_we_0(ram_we_0), .ram_addr_0(ram_addr_0), .ram_wdata_0(ram_wdata_0), .ram_rdata_0(ram_rdata_0),
    .ram_we_1(ram_we_1), .ram_addr_1(ram_addr_1), .ram_wdata_1(ram_wdata_1), .ram_rdata_1(ram_rdata_1)
  );

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  // Behavioural dual-port RAM: registered read, write on the same edge.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  bit mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int a = 0; a < (1<<AW); a++) mem[a] <= init_val(AW'(a));
      mem_ready <= 1'b1;
    end else begin
      if (ram_we_0) mem[ram_addr_0] <= ram_wdata_0;
      if (ram_we_1) mem[ram_addr_1] <= ram_wdata_1;
      ram_rdata_0 <= mem[ram_addr_0];
      ram_rdata_1 <= mem[ram_addr_1];
    end
  end

  typedef struct packed {
    logic [N-1:0]  v;
    logic [DW-1:0] d;
  } resp_t;

  resp_t exp_q[$];
  resp_t mon_e;
  int    checks = 0;
  int    failures = 0;
  int    gcount [N] = '{default: 0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = v;
    req_write[i]          = w;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic push_resp(input int i, input logic [DW-1:0] d);
    resp_t e;
    e.v    = '0;
    e.v[i] = 1'b1;
    e.d    = d;
    exp_q.push_back(e);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string name, input logic [N-1:0] exp_rdy);
    @(negedge clk);
    chk(name, 64'(req_ready), 64'(exp_rdy));
    adv();
  endtask

  task automatic idle_chk(input string name, input logic [N-1:0] exp_rv);
    @(negedge clk);
    chk(name, 64'(resp_valid), 64'(exp_rv));
    chk({name, "_rdy"}, 64'(req_ready), 64'(0));
    adv();
  endtask

  function automatic logic [AW-1:0] t5_addr(input int i, input int g);
    return AW'(32'h200 + 32'(16*i + g));
  endfunction

  // Response monitor: every non-zero resp_valid must match the head of the queue.
  always @(negedge clk) begin
    if (resp_valid != '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL resp_unexpected actual v=%b d=%h required none", resp_valid, resp_rdata);
      end else begin
        mon_e = exp_q.pop_front();
        if ({resp_valid, resp_rdata} !== mon_e) begin
          failures++;
          $display("FAIL resp actual v=%b d=%h required v=%b d=%h",
                   resp_valid, resp_rdata, mon_e.v, mon_e.d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] exp_g;
    clear_reqs();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, AW'(32'h100 + 32'(i)), '0);

    // Reset with all requesters valid: every output held at zero.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_resp_rdata", 64'(resp_rdata), 64'(0));
    chk("rst_we", 64'({ram_we_0, ram_we_1}), 64'(0));
    chk("rst_addr", 64'({ram_addr_0, ram_addr_1}), 64'(0));
    chk("rst_wdata", 64'({ram_wdata_0, ram_wdata_1}), 64'(0));
    adv();
    reset_n = 1'b1;

    push_resp(0, init_val(10'h100));
    push_resp(1, init_val(10'h101));
    @(negedge clk);
    chk("t1_ready", 64'(req_ready), 64'(4'b0011));
    chk("t1_addr0", 64'(ram_addr_0), 64'(10'h100));
    chk("t1_addr1", 64'(ram_addr_1), 64'(10'h101));
    adv();
    clear_reqs();
    idle_chk("t1_resp_a", 4'b0001);
    idle_chk("t1_resp_b", 4'b0010);

    // Single write then read-after-write of address 5 by requester 0.
    set_req(0, 1'b1, 1'b1, 10'h005, 32'hDEADBEEF);
    @(negedge clk);
    chk("t2_wr_ready", 64'(req_ready), 64'(4'b0001));
    chk("t2_wr_we", 64'({ram_we_0, ram_we_1}), 64'(2'b10));
    chk("t2_wr_addr", 64'(ram_addr_0), 64'(10'h005));
    chk("t2_wr_data", 64'(ram_wdata_0), 64'(32'hDEADBEEF));
    adv();
    set_req(0, 1'b1, 1'b0, 10'h005, '0);
    push_resp(0, 32'hDEADBEEF);
    cyc("t2_rd_ready", 4'b0001);
    clear_reqs();
    idle_chk("t2_resp", 4'b0001);

    // Write collision at 0x010: req1 first, req2 next cycle, req2 data wins.
    set_req(1, 1'b1, 1'b1, 10'h010, 32'h1111_1111);
    set_req(2, 1'b1, 1'b1, 10'h010, 32'h2222_2222);
    cyc("t3_first", 4'b0010);
    set_req(1, 1'b0, 1'b0, '0, '0);
    cyc("t3_second", 4'b0100);
    clear_reqs();
    set_req(3, 1'b1, 1'b0, 10'h010, '0);
    push_resp(3, 32'h2222_2222);
    cyc("t3_rd_ready", 4'b1000);
    clear_reqs();
    idle_chk("t3_resp", 4'b1000);

    // Read sharing at 0x020: both granted, req3 answered through the holding register.
    set_req(0, 1'b1, 1'b0, 10'h020, '0);
    set_req(3, 1'b1, 1'b0, 10'h020, '0);
    push_resp(0, init_val(10'h020));
    push_resp(3, init_val(10'h020));
    @(negedge clk);
    chk("t4_ready", 64'(req_ready), 64'(4'b1001));
    chk("t4_addrs", 64'({ram_addr_0, ram_addr_1}), 64'({10'h020, 10'h020}));
    adv();
    clear_reqs();
    idle_chk("t4_resp_n1", 4'b0001);
    idle_chk("t4_resp_n2", 4'b1000);

    // Read/write conflict skip, then read blocking while the holding register loads.
    set_req(0, 1'b1, 1'b0, 10'h030, '0);
    set_req(1, 1'b1, 1'b1, 10'h030, 32'hABCD_1234);
    set_req(2, 1'b1, 1'b0, 10'h031, '0);
    push_resp(0, init_val(10'h030));
    push_resp(2, init_val(10'h031));
    cyc("tc_ready", 4'b0101);
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(2, 1'b0, 1'b0, '0, '0);
    set_req(3, 1'b1, 1'b0, 10'h032, '0);
    @(negedge clk);
    chk("tc_blocked_ready", 64'(req_ready), 64'(4'b0010));
    chk("tc_blocked_we", 64'({ram_we_0, ram_we_1}), 64'(2'b10));
    chk("tc_blocked_resp", 64'(resp_valid), 64'(4'b0001));
    adv();
    set_req(1, 1'b0, 1'b0, '0, '0);
    push_resp(3, init_val(10'h032));
    @(negedge clk);
    chk("tc_late_ready", 64'(req_ready), 64'(4'b1000));
    chk("tc_hold_resp", 64'(resp_valid), 64'(4'b0100));
    adv();
    clear_reqs();
    idle_chk("tc_resp_last", 4'b1000);

    // Fairness: all four reading distinct addresses for 8 cycles.
    for (int c = 0; c < 8; c++) begin
      exp_g = (c % 2 == 1) ? 4'b0000 : ((c % 4 == 0) ? 4'b0011 : 4'b1100);
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, t5_addr(i, gcount[i]), '0);
      for (int i = 0; i < N; i++) begin
        if (exp_g[i]) begin
          push_resp(i, init_val(t5_addr(i, gcount[i])));
          gcount[i]++;
        end
      end
      cyc("t5_grant", exp_g);
    end
    clear_reqs();
    idle_chk("t5_resp_tail", 4'b1000);
    idle_chk("t5_idle", 4'b0000);

    // Mid-operation reset right after a read grant: the read never answers.
    set_req(1, 1'b1, 1'b0, 10'h040, '0);
    @(negedge clk);
    chk("t6_grant", 64'(req_ready), 64'(4'b0010));
    adv();
    reset_n = 1'b0;
    clear_reqs();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, AW'(32'h100 + 32'(i)), '0);
    @(negedge clk);
    chk("t6_rst_resp", 64'(resp_valid), 64'(0));
    chk("t6_rst_ready", 64'(req_ready), 64'(0));
    chk("t6_rst_ram", 64'({ram_we_0, ram_addr_0}), 64'(0));
    adv();
    adv();
    reset_n = 1'b1;
    push_resp(0, init_val(10'h100));
    push_resp(1, init_val(10'h101));
    cyc("t6_first_after_rst", 4'b0011);
    clear_reqs();

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) adv();
    chk("drain_outstanding", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
